// File: rtl/timer_ctrl.sv
// BCD mm:ss countdown timer with load/start/pause/clear commands and a one-second tick input.
// Optional alarm output enabled by defining TIMER_CTRL_ALARM_EN; otherwise alarm is tied low.
module timer_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_in,
   input  logic       load,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       start,
   input  logic       pause,
   input  logic       clear,
   output logic [7:0] min_out,
   output logic [7:0] sec_out,
   output logic       running,
   output logic       done,
   output logic       alarm
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t     state_q, state_d;
   logic [7:0] min_q, min_d, sec_q, sec_d;
   logic [7:0] min_dec, sec_dec;
   logic       tick_q;
   logic       tick_rise, load_ok, cnt_zero;

   assign tick_rise = tick_in & ~tick_q;
   assign cnt_zero  = (min_q == 8'h00) && (sec_q == 8'h00);
   // tens digit <= 5 also guarantees the value is <= 59
   assign load_ok   = (load_min[7:4] <= 4'd5) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);

   // One-second BCD decrement; only used in RUN, where the count is never 00:00.
   always_comb begin
      min_dec = min_q;
      sec_dec = sec_q;
      if (sec_q == 8'h00) begin
         sec_dec = 8'h59;
         if (min_q[3:0] == 4'd0) min_dec = {min_q[7:4] - 4'd1, 4'd9};
         else                    min_dec = {min_q[7:4], min_q[3:0] - 4'd1};
      end else if (sec_q[3:0] == 4'd0) begin
         sec_dec = {sec_q[7:4] - 4'd1, 4'd9};
      end else begin
         sec_dec = {sec_q[7:4], sec_q[3:0] - 4'd1};
      end
   end

   always_comb begin
      state_d = state_q;
      min_d   = min_q;
      sec_d   = sec_q;
      if (clear) begin
         state_d = IDLE;
         min_d   = 8'h00;
         sec_d   = 8'h00;
      end else if (state_q == RUN) begin
         if (pause) begin
            state_d = PAUSE;
         end else if (tick_rise) begin
            min_d = min_dec;
            sec_d = sec_dec;
            if ({min_dec, sec_dec} == 16'h0000) state_d = DONE;
         end
      end else if (load && load_ok) begin
         state_d = IDLE;
         min_d   = load_min;
         sec_d   = load_sec;
      end else if (start && (state_q != DONE) && !cnt_zero) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         tick_q  <= tick_in;
      end
   end

   assign min_out = min_q;
   assign sec_out = sec_q;
   assign running = (state_q == RUN);
   assign done    = (state_q == DONE);

`ifdef TIMER_CTRL_ALARM_EN
   logic alarm_q, alarm_d;

   // Toggles only on ticks seen while staying in DONE; any exit forces it low.
   always_comb begin
      alarm_d = 1'b0;
      if (state_q == DONE && state_d == DONE) alarm_d = alarm_q ^ tick_rise;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) alarm_q <= 1'b0;
      else     alarm_q <= alarm_d;
   end

   assign alarm = alarm_q;
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_timer_ctrl.sv
// Table-driven bench for timer_ctrl: per-cycle vectors with a scoreboard queue,
// plus hand-written asynchronous reset sequences.
module tb_timer_ctrl;

`ifdef TIMER_CTRL_ALARM_EN
   localparam bit ALARM_EN = 1'b1;
`else
   localparam bit ALARM_EN = 1'b0;
`endif

   logic       clk, rst, tick_in, load, start, pause, clear;
   logic [7:0] load_min, load_sec, min_out, sec_out;
   logic       running, done, alarm;

   timer_ctrl dut (
      .clk(clk), .rst(rst), .tick_in(tick_in), .load(load),
      .load_min(load_min), .load_sec(load_sec), .start(start),
      .pause(pause), .clear(clear), .min_out(min_out), .sec_out(sec_out),
      .running(running), .done(done), .alarm(alarm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       tick, ld;
      logic [7:0] lm, ls;
      logic       st, pa, cl;
      logic [7:0] em, es;
      logic       er, ed, ea;
   } vec_t;

   vec_t vecs[$];
   vec_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   rst_at  = -1;

   // reference count kept as plain seconds, converted to BCD for the table
   int   m_cnt;
   bit   m_run, m_done, m_alarm;

   function automatic logic [7:0] bcd(input int x);
      return 8'(((x / 10) << 4) | (x % 10));
   endfunction

   task automatic row(input logic t, ld, input logic [7:0] lm, ls,
                      input logic st, pa, cl, input int ecnt,
                      input logic er, ed, ea);
      vec_t v;
      v.tick = t; v.ld = ld; v.lm = lm; v.ls = ls;
      v.st = st; v.pa = pa; v.cl = cl;
      v.em = bcd(ecnt / 60); v.es = bcd(ecnt % 60);
      v.er = er; v.ed = ed; v.ea = ea;
      vecs.push_back(v);
      m_cnt = ecnt; m_run = er; m_done = ed; m_alarm = ea;
   endtask

   // one rising edge of tick_in followed by its low cycle
   task automatic tick();
      int  c = m_cnt;
      bit  r = m_run, d = m_done, a = m_alarm;
      if (r) begin
         c--;
         if (c == 0) begin r = 0; d = 1; end
      end else if (d) begin
         a = ~a;
      end
      row(1, 0, 8'h00, 8'h00, 0, 0, 0, c, r, d, a);
      row(0, 0, 8'h00, 8'h00, 0, 0, 0, c, r, d, a);
   endtask

   task automatic cmd_load(input logic [7:0] lm, ls, input int ecnt);
      row(0, 1, lm, ls, 0, 0, 0, ecnt, 0, 0, 0);
   endtask

   task automatic check(input string name, input vec_t e);
      logic ea;
      ea = ALARM_EN ? e.ea : 1'b0;
      n_tests++;
      if (min_out !== e.em || sec_out !== e.es || running !== e.er ||
          done !== e.ed || alarm !== ea) begin
         n_fail++;
         $display("FAIL %s: got %h:%h run=%b done=%b alarm=%b, want %h:%h run=%b done=%b alarm=%b",
                  name, min_out, sec_out, running, done, alarm, e.em, e.es, e.er, e.ed, ea);
      end
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if (min_out !== 8'h00 || sec_out !== 8'h00 || running !== 1'b0 ||
          done !== 1'b0 || alarm !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got %h:%h run=%b done=%b alarm=%b, want 00:00 run=0 done=0 alarm=0",
                  name, min_out, sec_out, running, done, alarm);
      end
   endtask

   task automatic drive_idle();
      tick_in = 0; load = 0; load_min = 0; load_sec = 0;
      start = 0; pause = 0; clear = 0;
   endtask

   // reset pulse between clock edges, checked before any further edge
   task automatic async_reset();
      @(negedge clk);
      drive_idle();
      #2 rst = 1'b1;
      #1 check_zero("async_rst_immediate");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 check_zero("after_rst_idle");
   endtask

   initial begin
      vec_t v, e;
      rst = 1'b1;
      drive_idle();
      #1 check_zero("reset_state");

      // 00:03 countdown into DONE, then alarm pattern, start ignored in DONE
      m_cnt = 0; m_run = 0; m_done = 0; m_alarm = 0;
      cmd_load(8'h00, 8'h03, 3);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 3, 1, 0, 0);
      for (int k = 0; k < 3; k++) tick();
      for (int k = 0; k < 4; k++) tick();
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, m_alarm);
      tick();
      row(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0);

      // 01:00 -> 00:59 minute borrow, then 60 ticks into DONE
      cmd_load(8'h01, 8'h00, 60);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 60, 1, 0, 0);
      tick();
      for (int k = 0; k < 60; k++) tick();
      row(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0);

      // pause coinciding with a tick, ticks while paused, resume
      cmd_load(8'h00, 8'h10, 10);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 10, 1, 0, 0);
      row(1, 0, 8'h00, 8'h00, 0, 1, 0, 10, 0, 0, 0);
      row(0, 0, 8'h00, 8'h00, 0, 0, 0, 10, 0, 0, 0);
      for (int k = 0; k < 5; k++) tick();
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 10, 1, 0, 0);
      tick();
      row(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0);

      // invalid loads ignored, start at 00:00 ignored, 59:59 accepted
      cmd_load(8'h00, 8'h5A, 0);
      cmd_load(8'h00, 8'h60, 0);
      cmd_load(8'h1A, 8'h00, 0);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0);
      cmd_load(8'h59, 8'h59, 3599);
      row(0, 0, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0);

      // level-high tick counts once; load ignored in RUN; then reset mid-run
      cmd_load(8'h02, 8'h30, 150);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 150, 1, 0, 0);
      tick();
      row(1, 0, 8'h00, 8'h00, 0, 0, 0, 148, 1, 0, 0);
      row(1, 0, 8'h00, 8'h00, 0, 0, 0, 148, 1, 0, 0);
      row(1, 0, 8'h00, 8'h00, 0, 0, 0, 148, 1, 0, 0);
      row(0, 1, 8'h00, 8'h05, 0, 0, 0, 148, 1, 0, 0);
      rst_at = vecs.size();
      cmd_load(8'h02, 8'h30, 150);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 150, 1, 0, 0);
      tick();
      row(0, 0, 8'h00, 8'h00, 0, 1, 0, 149, 0, 0, 0);
      row(0, 1, 8'h02, 8'h30, 0, 0, 1, 0, 0, 0, 0);
      row(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 0, 0, 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i == rst_at) async_reset();
         v = vecs[i];
         @(negedge clk);
         tick_in = v.tick; load = v.ld; load_min = v.lm; load_sec = v.ls;
         start = v.st; pause = v.pa; clear = v.cl;
         exp_q.push_back(v);
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         check($sformatf("row%0d", i), e);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
